// File: rtl/pipe_stage_skid_pkg.sv
// Shared types for the generic pipeline stage: state encoding, NOP constant, stage bundles.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pipe_pkg;

    // The encoding doubles as the occupancy count (0/1/2 entries held).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // The instruction sits in the low bits, so an all-zero bubble reads as a NOP.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pcplus4;
        logic [31:0] instr;
    } fd_bundle_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [2:0] alu_ctrl;
        logic       alu_src;
        logic [1:0] imm_src;
    } ctrl_t;

    typedef struct packed {
        ctrl_t      ctrl;
        fd_bundle_t fd;
    } de_bundle_t;

    localparam int FD_W = $bits(fd_bundle_t);
    localparam int DE_W = $bits(de_bundle_t);

    function automatic logic [1:0] occ_of(stage_state_e st);
        return 2'(st);
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready payload channel between two pipeline stages.
// Latency: n/a (wires only).
// Backpressure: transfer happens when valid & ready; master holds data while valid & !ready.
//   master: drives valid, data; samples ready
//   slave : samples valid, data; drives ready
interface pipe_stage_skid_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = FD_W
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones.
// Latency: q reflects an increment one cycle after inc.
// Backpressure: none.
//   ports: clk, rst_n (async active-low), inc, q[CNT_W-1:0]
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (inc && (q != {CNT_W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, sync flush and optional 2-entry skid.
// Latency: 1 cycle in to out. SKID=1: in_ready is a flop (low only when both entries are full);
// SKID=0: single entry, in_ready = !out_valid | out_ready. Perf counters only with PIPE_STAGE_PERF_CNT_EN.
//   ports: clk, rst_n, flush_i, up (slave: in_valid/in_ready/in_data), dn (master: out_valid/out_ready/out_data),
//          occupancy[1:0], stall_cnt, flush_cnt
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = FD_W,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int                SKID       = 1,
    parameter int                CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    pipe_stage_skid_if.slave   up,
    pipe_stage_skid_if.master  dn,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              out_valid;
    logic              in_fire;
    logic              out_fire;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = up.valid & up.ready;
    assign out_fire  = out_valid & dn.ready;

    generate
        if (SKID != 0) begin : g_skid
            // Registered ready: computed from next state so it never sees out_ready combinationally.
            logic rdy_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdy_q <= 1'b1;
                end else begin
                    rdy_q <= (state_d != ST_TWO);
                end
            end
            assign up.ready = rdy_q;
        end else begin : g_noskid
            assign up.ready = !out_valid | dn.ready;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            // A coincident in_fire is dropped here; a coincident out_fire has already
            // been taken by downstream this cycle.
            state_d = ST_EMPTY;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = up.data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = up.data;
                    end else if (in_fire) begin
                        // Downstream stalled: park the newcomer behind the head. Without the
                        // skid buffer in_ready equals out_ready here, so this is unreachable.
                        state_d = ST_TWO;
                        skid_d  = up.data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE_VAL;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VAL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE_VAL;
                    skid_d  = BUBBLE_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE_VAL;
            skid_q  <= BUBBLE_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign dn.valid  = out_valid;
    assign dn.data   = main_q;
    assign occupancy = occ_of(state_q);

`ifdef PIPE_STAGE_PERF_CNT_EN
    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid & ~dn.ready),
        .q     (stall_cnt)
    );

    // Only flushes that actually discard something are counted.
    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_i & out_valid),
        .q     (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a SKID=1 instance (CNT_W=4) driven from a vector table plus
// directed corner sequences, and a SKID=0 instance checked against an in-order queue model.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int             DW  = 16;
    localparam logic [DW-1:0]  BUB = 16'hBEEF;

`ifdef PIPE_STAGE_PERF_CNT_EN
    localparam int EXP_STALL_TBL = 4;
    localparam int EXP_FLUSH_TBL = 2;
    localparam int EXP_STALL_SAT = 15;
`else
    localparam int EXP_STALL_TBL = 0;
    localparam int EXP_FLUSH_TBL = 0;
    localparam int EXP_STALL_SAT = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic flush_a;
    logic flush_b = 1'b0;

    logic [1:0]  a_occ, b_occ;
    logic [3:0]  a_stall, a_flush;
    logic [15:0] b_stall, b_flush;

    pipe_stage_skid_if #(.DATA_W(DW)) a_up ();
    pipe_stage_skid_if #(.DATA_W(DW)) a_dn ();
    pipe_stage_skid_if #(.DATA_W(DW)) b_up ();
    pipe_stage_skid_if #(.DATA_W(DW)) b_dn ();

    pipe_stage_skid #(.DATA_W(DW), .BUBBLE_VAL(BUB), .SKID(1), .CNT_W(4)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flush_a),
        .up        (a_up.slave),
        .dn        (a_dn.master),
        .occupancy (a_occ),
        .stall_cnt (a_stall),
        .flush_cnt (a_flush)
    );

    pipe_stage_skid #(.DATA_W(DW), .BUBBLE_VAL(BUB), .SKID(0), .CNT_W(16)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flush_b),
        .up        (b_up.slave),
        .dn        (b_dn.master),
        .occupancy (b_occ),
        .stall_cnt (b_stall),
        .flush_cnt (b_flush)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          fl;
        logic          e_vld;
        logic [DW-1:0] e_dat;
        logic          e_rdy;
        logic [1:0]    e_occ;
    } vec_t;

    function automatic vec_t mk(logic iv, logic [DW-1:0] d, logic ordy, logic fl,
                                logic ev, logic [DW-1:0] ed, logic er, logic [1:0] eo);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.e_vld = ev; v.e_dat = ed; v.e_rdy = er; v.e_occ = eo;
        return v;
    endfunction

    // In-order model for the SKID=0 instance.
    logic [DW-1:0] sb_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            check("b in_ready comb", 32'(b_up.ready), 32'(!b_dn.valid | b_dn.ready));
            if (b_dn.valid && b_dn.ready) begin
                check("b out with model non-empty", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    check("b order", 32'(b_dn.data), 32'(sb_q.pop_front()));
                end
            end
            if (b_up.valid && b_up.ready) begin
                sb_q.push_back(b_up.data);
            end
        end
    end

    vec_t tbl [16];

    initial begin
        // inputs: iv, d, out_ready, flush -> expected after edge: out_valid, out_data, in_ready, occupancy
        tbl[0]  = mk(1, 16'd1,  1, 0,  1, 16'd1,  1, 2'd1);
        tbl[1]  = mk(1, 16'd2,  1, 0,  1, 16'd2,  1, 2'd1);
        tbl[2]  = mk(1, 16'd3,  1, 0,  1, 16'd3,  1, 2'd1);
        tbl[3]  = mk(0, 16'd0,  1, 0,  0, BUB,    1, 2'd0);
        tbl[4]  = mk(1, 16'd5,  0, 0,  1, 16'd5,  1, 2'd1);
        tbl[5]  = mk(1, 16'd6,  0, 0,  1, 16'd5,  0, 2'd2);
        tbl[6]  = mk(1, 16'd7,  0, 0,  1, 16'd5,  0, 2'd2);
        tbl[7]  = mk(0, 16'd0,  1, 0,  1, 16'd6,  1, 2'd1);
        tbl[8]  = mk(0, 16'd0,  1, 0,  0, BUB,    1, 2'd0);
        tbl[9]  = mk(1, 16'd7,  0, 0,  1, 16'd7,  1, 2'd1);
        tbl[10] = mk(1, 16'd8,  0, 0,  1, 16'd7,  0, 2'd2);
        tbl[11] = mk(1, 16'd9,  1, 1,  0, BUB,    1, 2'd0);
        tbl[12] = mk(0, 16'd0,  1, 0,  0, BUB,    1, 2'd0);
        tbl[13] = mk(0, 16'd0,  1, 1,  0, BUB,    1, 2'd0);
        tbl[14] = mk(1, 16'd10, 0, 0,  1, 16'd10, 1, 2'd1);
        tbl[15] = mk(0, 16'd0,  0, 1,  0, BUB,    1, 2'd0);

        rst_n = 1'b1;
        flush_a = 1'b0;
        a_up.valid = 1'b0; a_up.data = '0; a_dn.ready = 1'b0;
        b_up.valid = 1'b0; b_up.data = '0; b_dn.ready = 1'b0;

        // Reset state
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst a out_valid", 32'(a_dn.valid), 32'd0);
        check("rst a out_data",  32'(a_dn.data),  32'(BUB));
        check("rst a occupancy", 32'(a_occ),      32'd0);
        check("rst a in_ready",  32'(a_up.ready), 32'd1);
        check("rst a stall_cnt", 32'(a_stall),    32'd0);
        check("rst a flush_cnt", 32'(a_flush),    32'd0);
        check("rst b out_data",  32'(b_dn.data),  32'(BUB));
        rst_n = 1'b1;

        // Reset mid-transfer: two entries held, then async reset between edges
        a_up.valid = 1'b1; a_up.data = 16'hA; a_dn.ready = 1'b0;
        @(posedge clk); #1;
        check("mt a occupancy before", 32'(a_occ), 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mt a out_valid", 32'(a_dn.valid), 32'd0);
        check("mt a out_data",  32'(a_dn.data),  32'(BUB));
        check("mt a occupancy", 32'(a_occ),      32'd0);
        check("mt a in_ready",  32'(a_up.ready), 32'd1);
        check("mt a stall_cnt", 32'(a_stall),    32'd0);
        a_up.valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Table: streaming, skid fill/drain, flush collisions
        for (int i = 0; i < 16; i++) begin
            a_up.valid = tbl[i].iv;
            a_up.data  = tbl[i].d;
            a_dn.ready = tbl[i].ordy;
            flush_a    = tbl[i].fl;
            @(posedge clk); #1;
            check($sformatf("v%0d out_valid", i), 32'(a_dn.valid), 32'(tbl[i].e_vld));
            check($sformatf("v%0d out_data", i),  32'(a_dn.data),  32'(tbl[i].e_dat));
            check($sformatf("v%0d in_ready", i),  32'(a_up.ready), 32'(tbl[i].e_rdy));
            check($sformatf("v%0d occupancy", i), 32'(a_occ),      32'(tbl[i].e_occ));
        end
        flush_a = 1'b0;
        check("tbl stall_cnt", 32'(a_stall), 32'(EXP_STALL_TBL));
        check("tbl flush_cnt", 32'(a_flush), 32'(EXP_FLUSH_TBL));

        // Fill both entries, then show in_ready ignores out_ready within the cycle
        a_up.valid = 1'b1; a_up.data = 16'h21; a_dn.ready = 1'b0;
        @(posedge clk); #1;
        a_up.data = 16'h22;
        @(posedge clk); #1;
        a_up.valid = 1'b0;
        check("two occupancy", 32'(a_occ),      32'd2);
        check("two in_ready",  32'(a_up.ready), 32'd0);
        a_dn.ready = 1'b1; #1;
        check("two in_ready ordy=1", 32'(a_up.ready), 32'd0);
        a_dn.ready = 1'b0; #1;
        check("two in_ready ordy=0", 32'(a_up.ready), 32'd0);

        // Long stall: counter saturates, head payload stays put
        repeat (20) @(posedge clk);
        #1;
        check("sat stall_cnt", 32'(a_stall),   32'(EXP_STALL_SAT));
        check("sat out_data",  32'(a_dn.data), 32'h21);
        check("sat occupancy", 32'(a_occ),     32'd2);

        a_dn.ready = 1'b1;
        @(posedge clk); #1;
        check("drain a second", 32'(a_dn.data), 32'h22);
        check("drain a occ",    32'(a_occ),     32'd1);
        @(posedge clk); #1;
        check("drain a out_valid", 32'(a_dn.valid), 32'd0);
        check("drain a out_data",  32'(a_dn.data),  32'(BUB));
        check("drain a flush_cnt", 32'(a_flush),    32'(EXP_FLUSH_TBL));
        a_dn.ready = 1'b0;

        // SKID=0: combinational ready following out_ready
        check("b empty in_ready", 32'(b_up.ready), 32'd1);
        b_up.valid = 1'b1; b_up.data = 16'h11;
        @(posedge clk); #1;
        b_up.valid = 1'b0;
        #1;
        check("b out_valid",     32'(b_dn.valid), 32'd1);
        check("b out_data",      32'(b_dn.data),  32'h11);
        check("b in_ready ordy0", 32'(b_up.ready), 32'd0);
        b_dn.ready = 1'b1; #1;
        check("b in_ready ordy1", 32'(b_up.ready), 32'd1);
        b_dn.ready = 1'b0; #1;
        check("b in_ready back0", 32'(b_up.ready), 32'd0);
        b_up.valid = 1'b1; b_up.data = 16'h22; b_dn.ready = 1'b1;
        @(posedge clk); #1;
        check("b replace data", 32'(b_dn.data), 32'h22);
        check("b replace occ",  32'(b_occ),     32'd1);

        for (int i = 0; i < 60; i++) begin
            b_up.valid = 1'($urandom_range(0, 1));
            b_up.data  = 16'(16'h100 + i);
            b_dn.ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        b_up.valid = 1'b0; b_dn.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("b drained out_valid", 32'(b_dn.valid), 32'd0);
        check("b drained model",     32'(sb_q.size()), 32'd0);
        check("b flush_cnt",         32'(b_flush),     32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
